matmul_host_ctrl: RTL and testbench

Host-side controller that drives the operand-load, start and result-capture interface of the generic M×N × N×P matrix multiplier.
- Accepts a valid/ready stream of operand words: A in row-major order, then B in row-major order.
- Writes each word into the multiplier through its addr/wen ports, then runs the start/done handshake.
- Captures the row-major C stream into a local result buffer, which a consumer reads by address.

---
 rtl/matmul_host_ctrl_if.sv | 44 ++++
 rtl/matmul_host_ctrl.sv | 142 ++++++++++++++
 tb/tb_matmul_host_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_host_ctrl_if.sv
// Host-side bus of the matrix-multiplier controller: operand stream, multiplier
// load/start/result port, result-buffer read port and status.
interface matmul_host_ctrl_if #(
    parameter int M          = 3,
    parameter int N          = 3,
    parameter int P          = 3,
    parameter int DATA_WIDTH = 8
);
    localparam int AW = $clog2(M*N);
    localparam int BW = $clog2(N*P);
    localparam int CW = $clog2(M*P);

    logic signed [DATA_WIDTH-1:0]   op_data;
    logic                           op_valid;
    logic                           op_ready;
    logic signed [DATA_WIDTH-1:0]   mm_a_in;
    logic [AW-1:0]                  mm_a_addr;
    logic                           mm_a_wen;
    logic signed [DATA_WIDTH-1:0]   mm_b_in;
    logic [BW-1:0]                  mm_b_addr;
    logic                           mm_b_wen;
    logic                           mm_start;
    logic signed [2*DATA_WIDTH-1:0] mm_c_out;
    logic                           mm_c_valid;
    logic                           mm_done;
    logic [CW-1:0]                  rd_addr;
    logic signed [2*DATA_WIDTH-1:0] rd_data;
    logic                           results_valid;
    logic                           release_req;
    logic                           busy;
    logic                           count_err;

    modport master (
        input  op_data, op_valid, mm_c_out, mm_c_valid, mm_done, rd_addr, release_req,
        output op_ready, mm_a_in, mm_a_addr, mm_a_wen, mm_b_in, mm_b_addr, mm_b_wen,
        output mm_start, rd_data, results_valid, busy, count_err
    );

    modport slave (
        output op_data, op_valid, mm_c_out, mm_c_valid, mm_done, rd_addr, release_req,
        input  op_ready, mm_a_in, mm_a_addr, mm_a_wen, mm_b_in, mm_b_addr, mm_b_wen,
        input  mm_start, rd_data, results_valid, busy, count_err
    );
endinterface

// File: rtl/matmul_host_ctrl.sv
// Host controller for the M x N * N x P multiplier: streams A then B into the
// multiplier, runs start/done, and buffers the returned C elements for readback.
module matmul_host_ctrl #(
    parameter int M          = 3,
    parameter int N          = 3,
    parameter int P          = 3,
    parameter int DATA_WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    matmul_host_ctrl_if.master io_bus
);
    localparam int NA  = M*N;
    localparam int NB  = N*P;
    localparam int NC  = M*P;
    localparam int AW  = $clog2(NA);
    localparam int BW  = $clog2(NB);
    localparam int CW  = $clog2(NC);
    localparam int LW  = (AW > BW) ? AW : BW;
    localparam int DW2 = 2*DATA_WIDTH;
    localparam logic [CW:0] NC_W = (CW+1)'(NC);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_HOLD   = 3'd6;

    logic [2:0]                    r_state;
    logic [LW-1:0]                 r_ld_cnt;
    logic [CW:0]                   r_res_cnt;
    logic                          r_count_err;
    logic                          r_a_wen;
    logic                          r_b_wen;
    logic [AW-1:0]                 r_a_addr;
    logic [BW-1:0]                 r_b_addr;
    logic signed [DATA_WIDTH-1:0]  r_a_in;
    logic signed [DATA_WIDTH-1:0]  r_b_in;
    logic signed [DW2-1:0]         r_cbuf [NC];
    logic signed [DW2-1:0]         r_rd_data;

    logic        w_load;
    logic        w_hs;
    logic        w_cap;
    logic        w_drop;
    logic [CW:0] w_cnt_final;

    assign w_load      = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_hs        = w_load && io_bus.op_valid;
    assign w_cap       = (r_state == S_WAIT) && io_bus.mm_c_valid && (r_res_cnt < NC_W);
    assign w_drop      = (r_state == S_WAIT) && io_bus.mm_c_valid && (r_res_cnt >= NC_W);
    // An element arriving together with mm_done still counts toward the check.
    assign w_cnt_final = r_res_cnt + (CW+1)'(w_cap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ld_cnt    <= '0;
            r_res_cnt   <= '0;
            r_count_err <= 1'b0;
            r_a_wen     <= 1'b0;
            r_b_wen     <= 1'b0;
            r_a_addr    <= '0;
            r_b_addr    <= '0;
            r_a_in      <= '0;
            r_b_in      <= '0;
        end else begin
            r_a_wen <= 1'b0;
            r_b_wen <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= S_LOAD_A;
                S_LOAD_A: if (w_hs) begin
                    r_a_wen  <= 1'b1;
                    r_a_addr <= r_ld_cnt[AW-1:0];
                    r_a_in   <= io_bus.op_data;
                    if (r_ld_cnt == LW'(NA-1)) begin
                        r_ld_cnt <= '0;
                        r_state  <= S_LOAD_B;
                    end else begin
                        r_ld_cnt <= r_ld_cnt + 1'b1;
                    end
                end
                S_LOAD_B: if (w_hs) begin
                    r_b_wen  <= 1'b1;
                    r_b_addr <= r_ld_cnt[BW-1:0];
                    r_b_in   <= io_bus.op_data;
                    if (r_ld_cnt == LW'(NB-1)) begin
                        r_ld_cnt <= '0;
                        r_state  <= S_START;
                    end else begin
                        r_ld_cnt <= r_ld_cnt + 1'b1;
                    end
                end
                // Gap cycle lets the final B write land before start rises.
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_cap)  r_res_cnt   <= r_res_cnt + 1'b1;
                    if (w_drop) r_count_err <= 1'b1;
                    if (io_bus.mm_done) begin
                        r_state <= S_DRAIN;
                        if (w_cnt_final != NC_W) r_count_err <= 1'b1;
                    end
                end
                S_DRAIN: if (!io_bus.mm_done) r_state <= S_HOLD;
                S_HOLD: if (io_bus.release_req) begin
                    r_state     <= S_LOAD_A;
                    r_res_cnt   <= '0;
                    r_count_err <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_cap) r_cbuf[r_res_cnt[CW-1:0]] <= io_bus.mm_c_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= ({1'b0, io_bus.rd_addr} < NC_W) ? r_cbuf[io_bus.rd_addr] : '0;
        end
    end

    assign io_bus.op_ready      = w_load;
    assign io_bus.mm_a_in       = r_a_in;
    assign io_bus.mm_a_addr     = r_a_addr;
    assign io_bus.mm_a_wen      = r_a_wen;
    assign io_bus.mm_b_in       = r_b_in;
    assign io_bus.mm_b_addr     = r_b_addr;
    assign io_bus.mm_b_wen      = r_b_wen;
    assign io_bus.mm_start      = (r_state == S_WAIT);
    assign io_bus.rd_data       = r_rd_data;
    assign io_bus.results_valid = (r_state == S_HOLD);
    assign io_bus.busy          = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign io_bus.count_err     = r_count_err;
endmodule

// File: tb/tb_matmul_host_ctrl.sv
// Bench for matmul_host_ctrl with a 2x2x2 multiplier model and a result-buffer
// model; directed operand sets with hand-computed products.
module tb_matmul_host_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_host_ctrl_if #(.M(2), .N(2), .P(2), .DATA_WIDTH(8)) bus ();

    matmul_host_ctrl #(.M(2), .N(2), .P(2), .DATA_WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.master)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         isb;
        logic [1:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t               exp_wr[$];
    logic signed [7:0] opsv[8];
    logic [15:0]       mbuf[4];
    logic signed [7:0] ma[4];
    logic signed [7:0] mb[4];
    int                npulse   = 4;
    bit                coincide = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Multiplier model: operand memories, then C pulses and the done handshake.
    always @(posedge clk) begin
        if (bus.mm_a_wen) ma[bus.mm_a_addr] <= bus.mm_a_in;
        if (bus.mm_b_wen) mb[bus.mm_b_addr] <= bus.mm_b_in;
    end

    function automatic logic [15:0] cval(input int k);
        int i = k / 2;
        int j = k % 2;
        int s = int'(ma[i*2]) * int'(mb[j]) + int'(ma[i*2+1]) * int'(mb[2+j]);
        return 16'(s);
    endfunction

    task automatic run_mm();
        bit ok = 1'b1;
        int g  = 0;
        logic [15:0] v;
        for (int k = 0; k < npulse && ok; k++) begin
            v = (k < 4) ? cval(k) : 16'h7777;
            bus.mm_c_out   = v;
            bus.mm_c_valid = 1'b1;
            if (k < 4) mbuf[k] = v;
            if (coincide && k == npulse - 1) bus.mm_done = 1'b1;
            @(negedge clk);
            bus.mm_c_valid = 1'b0;
            if (!rst_n) ok = 1'b0;
        end
        if (ok) begin
            bus.mm_done = 1'b1;
            while (bus.mm_start && rst_n && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) chk("start_drop_timeout", 32'(g), 32'd0);
        end
        bus.mm_done = 1'b0;
    endtask

    initial begin : mm_model
        bus.mm_c_valid = 1'b0;
        bus.mm_done    = 1'b0;
        bus.mm_c_out   = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mm_start) run_mm();
        end
    end

    // Per-cycle compare: write stream, status invariants, readback vs buffer model.
    logic [1:0] addr_q;
    logic       rv_q;
    always @(posedge clk) begin
        addr_q <= bus.rd_addr;
        rv_q   <= bus.results_valid;
    end

    always @(negedge clk) begin : cmp
        wr_t e;
        if (rst_n) begin
            if (bus.mm_a_wen || bus.mm_b_wen) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_both", {31'b0, bus.mm_a_wen & bus.mm_b_wen}, 32'd0);
                    chk("wr_kind", {31'b0, bus.mm_b_wen}, {31'b0, e.isb});
                    chk("wr_addr", e.isb ? {30'b0, bus.mm_b_addr} : {30'b0, bus.mm_a_addr}, {30'b0, e.addr});
                    chk("wr_data", e.isb ? {24'b0, bus.mm_b_in} : {24'b0, bus.mm_a_in}, {24'b0, e.data});
                end
            end
            chk("start_implies_busy", {31'b0, bus.mm_start & ~bus.busy}, 32'd0);
            chk("rv_exclusive", {31'b0, bus.results_valid & (bus.busy | bus.op_ready)}, 32'd0);
            if (rv_q && bus.results_valid)
                chk("rd_data_model", {16'b0, bus.rd_data}, {16'b0, mbuf[addr_q]});
        end
    end

    task automatic load_ops(input bit rnd);
        int idx = 0;
        int guard = 0;
        while (idx < 8 && guard < 300) begin
            @(negedge clk);
            guard++;
            bus.op_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.op_data  = opsv[idx];
            if (bus.op_valid && bus.op_ready) begin
                exp_wr.push_back('{isb: (idx >= 4), addr: 2'(idx % 4), data: opsv[idx]});
                idx++;
            end
        end
        if (idx < 8) chk("load_timeout", 32'(idx), 32'd8);
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic start_run(input bit rnd);
        load_ops(rnd);
        chk("start_low_t1", {31'b0, bus.mm_start}, 32'd0);
        chk("busy_in_start", {31'b0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("start_high_t2", {31'b0, bus.mm_start}, 32'd1);
    endtask

    task automatic wait_hold();
        int g = 0;
        while (!bus.results_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("hold_reached", {31'b0, bus.results_valid}, 32'd1);
        chk("writes_drained", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic read_c(input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] ev[4];
        ev = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.rd_addr = 2'(i);
            @(negedge clk);
            chk($sformatf("c%0d", i), {16'b0, bus.rd_data}, {16'b0, ev[i]});
        end
    endtask

    task automatic release_pulse();
        @(negedge clk);
        bus.release_req = 1'b1;
        @(negedge clk);
        bus.release_req = 1'b0;
        chk("rel_rv_clear", {31'b0, bus.results_valid}, 32'd0);
        chk("rel_err_clear", {31'b0, bus.count_err}, 32'd0);
        chk("rel_loading", {31'b0, bus.op_ready}, 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.op_valid    = 1'b0;
        bus.op_data     = '0;
        bus.rd_addr     = '0;
        bus.release_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_op_ready", {31'b0, bus.op_ready}, 32'd0);
        chk("rst_start", {31'b0, bus.mm_start}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_rv", {31'b0, bus.results_valid}, 32'd0);
        chk("rst_err", {31'b0, bus.count_err}, 32'd0);
        chk("rst_wen", {30'b0, bus.mm_a_wen, bus.mm_b_wen}, 32'd0);
        chk("rst_rd_data", {16'b0, bus.rd_data}, 32'd0);
        rst_n = 1'b1;

        // Basic product
        opsv = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
        start_run(1'b0);
        wait_hold();
        chk("t1_err", {31'b0, bus.count_err}, 32'd0);
        read_c(16'd19, 16'd22, 16'd43, 16'd50);
        release_pulse();

        // Signed operands
        opsv = '{-8'sd1, 8'sd2, 8'sd3, -8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
        start_run(1'b0);
        wait_hold();
        chk("t2_err", {31'b0, bus.count_err}, 32'd0);
        read_c(16'd9, 16'd10, 16'hFFF3, 16'hFFF2);
        release_pulse();

        // Gappy operand stream
        opsv = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
        start_run(1'b1);
        wait_hold();
        read_c(16'd19, 16'd22, 16'd43, 16'd50);
        release_pulse();

        // Short count: C[3] keeps the previous run's value
        npulse = 3;
        start_run(1'b0);
        wait_hold();
        chk("t4a_err", {31'b0, bus.count_err}, 32'd1);
        read_c(16'd19, 16'd22, 16'd43, 16'd50);
        release_pulse();

        // Excess pulse is dropped
        npulse = 5;
        start_run(1'b0);
        wait_hold();
        chk("t4b_err", {31'b0, bus.count_err}, 32'd1);
        read_c(16'd19, 16'd22, 16'd43, 16'd50);
        release_pulse();

        // Reset in the middle of WAIT
        npulse = 4;
        start_run(1'b0);
        @(negedge clk);
        chk("t5_pre_start", {31'b0, bus.mm_start}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_start_async", {31'b0, bus.mm_start}, 32'd0);
        chk("t5_busy_async", {31'b0, bus.busy}, 32'd0);
        chk("t5_rv_async", {31'b0, bus.results_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_run(1'b0);
        wait_hold();
        read_c(16'd19, 16'd22, 16'd43, 16'd50);
        release_pulse();

        // Second operand set, done coincident with last element, stray release in WAIT
        opsv = '{8'sd0, 8'sd1, 8'sd1, 8'sd0, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
        coincide = 1'b1;
        start_run(1'b0);
        @(negedge clk);
        bus.release_req = 1'b1;
        @(negedge clk);
        bus.release_req = 1'b0;
        chk("t6_busy_after_rel", {31'b0, bus.busy}, 32'd1);
        wait_hold();
        chk("t6_err", {31'b0, bus.count_err}, 32'd0);
        read_c(16'd7, 16'd8, 16'd5, 16'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
